// File: rtl/switch_debouncer.sv
// switch_debouncer: two-flop synchronizer plus per-bit stability counter for raw
// board switches. A debounced bit takes a new level only after the synchronized
// input has disagreed with it for STABLE_CYCLES consecutive clocks. Each accepted
// level change also produces a one-cycle rise or fall pulse.
//
// Ports:
//   clk       single clock, rising edge
//   rst       synchronous active-high reset
//   swt_raw   asynchronous raw switch levels (bit 2 -> A, bit 1 -> B, bit 0 -> C)
//   swt_db    debounced, registered switch levels
//   swt_rise  one-cycle pulse per bit on swt_db 0->1
//   swt_fall  one-cycle pulse per bit on swt_db 1->0
module switch_debouncer #(
    parameter int unsigned WIDTH         = 3,
    parameter int unsigned STABLE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] swt_raw,
    output logic [WIDTH-1:0] swt_db,
    output logic [WIDTH-1:0] swt_rise,
    output logic [WIDTH-1:0] swt_fall
);

    // Counter holds 0..STABLE_CYCLES-1; width kept at least 1 so a bad
    // parameter reaches the elaboration error below instead of a zero-width bus.
    localparam int unsigned CNT_W =
        (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST =
        (STABLE_CYCLES < 1) ? '0 : CNT_W'(STABLE_CYCLES - 1);

    if (STABLE_CYCLES < 1) begin : g_bad_stable_cycles
        $error("switch_debouncer: STABLE_CYCLES must be at least 1");
    end

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } state_e;

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;

    state_e           state_q [WIDTH];
    state_e           state_d [WIDTH];
    logic [CNT_W-1:0] cnt_q   [WIDTH];
    logic [CNT_W-1:0] cnt_d   [WIDTH];

    logic [WIDTH-1:0] db_d;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_d;
    logic [WIDTH-1:0] mismatch_c;

    // Synchronized level disagrees with the currently accepted level.
    assign mismatch_c = sync2 ^ swt_db;

    // State, counters, synchronizer and registered outputs; reset dominates.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            swt_db   <= '0;
            swt_rise <= '0;
            swt_fall <= '0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                state_q[i] <= ST_STABLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync1    <= swt_raw;
            sync2    <= sync1;
            swt_db   <= db_d;
            swt_rise <= rise_d;
            swt_fall <= fall_d;
            for (int i = 0; i < int'(WIDTH); i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Per-bit next state: count consecutive mismatch cycles, accept on the last.
    always_comb begin
        db_d   = swt_db;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            state_d[i] = ST_STABLE;
            cnt_d[i]   = '0;
        end

        for (int i = 0; i < int'(WIDTH); i++) begin
            case (state_q[i])
                ST_STABLE: begin
                    if (mismatch_c[i]) begin
                        if (CNT_LAST == '0) begin
                            // Single-cycle stability: accept on the first mismatch.
                            db_d[i]   = sync2[i];
                            rise_d[i] = sync2[i];
                            fall_d[i] = ~sync2[i];
                        end else begin
                            state_d[i] = ST_COUNTING;
                            cnt_d[i]   = CNT_W'(1);
                        end
                    end
                end

                ST_COUNTING: begin
                    if (!mismatch_c[i]) begin
                        // Mismatch vanished: drop all accumulated credit.
                        state_d[i] = ST_STABLE;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        db_d[i]   = sync2[i];
                        rise_d[i] = sync2[i];
                        fall_d[i] = ~sync2[i];
                    end else begin
                        state_d[i] = ST_COUNTING;
                        cnt_d[i]   = CNT_W'(cnt_q[i] + CNT_W'(1));
                    end
                end

                default: begin
                    state_d[i] = ST_STABLE;
                end
            endcase
        end
    end

endmodule
